// File: rtl/mdl_sd_cmd.sv
// SD card CMD-line model.
// The receiver decodes 48-bit host command frames and checks their CRC7.
// The transmitter serialises 48- or 136-bit card responses, either push-pull
// or open-drain. In open-drain mode it detects collisions on released one bits.
module mdl_sd_cmd (
    input  logic         sd_clk,
    input  logic         i_reset_n,
    inout  wire          sd_cmd,
    output logic         sd_ds,
    output logic         o_cmd_valid,
    output logic [5:0]   o_cmd,
    output logic [31:0]  o_arg,
    input  logic         i_valid,
    input  logic         i_type,
    input  logic [5:0]   i_reply,
    input  logic [119:0] i_arg,
    input  logic         i_use_crc,
    output logic         o_busy,
    input  logic         i_drive,
    output logic         o_collision
);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_WAIT = 2'd1,
        TX_SEND = 2'd2
    } tx_state_t;

    // One serial CRC7 step, polynomial x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Receiver state
    logic        line_in;
    logic        rx_active;
    logic [5:0]  rx_cnt;
    logic [45:0] rx_shift;
    logic [6:0]  rx_crc;
    logic        frame_ok;

    // Transmitter state
    tx_state_t    tx_state;
    tx_state_t    tx_next;
    logic [127:0] tx_shift;
    logic [6:0]   tx_crc;
    logic [7:0]   tx_cnt;
    logic         tx_type;
    logic         tx_use_crc;
    logic         tx_drive;
    logic [7:0]   data_len;
    logic [7:0]   crc_first;
    logic [7:0]   last_cnt;
    logic         cur_bit;
    logic         collide;
    logic         drive_en;
    logic         drive_val;

    // A floating or unknown line reads as the pulled-up level
    assign line_in = (sd_cmd === 1'b0) ? 1'b0 : 1'b1;
    assign sd_cmd  = drive_en ? drive_val : 1'bz;

    // rx_shift holds frame bits 1..46, with bit 1 (direction) at [45]
    assign frame_ok = rx_shift[45] && (rx_shift[6:0] == rx_crc) && line_in;

    // Receiver: hunt for a start bit, shift in 48 bits, and publish good frames
    always_ff @(posedge sd_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_active   <= 1'b0;
            rx_cnt      <= 6'd0;
            rx_shift    <= '0;
            rx_crc      <= 7'd0;
            o_cmd_valid <= 1'b0;
            o_cmd       <= 6'd0;
            o_arg       <= 32'd0;
        end else begin
            o_cmd_valid <= 1'b0;
            if (o_busy) begin
                rx_active <= 1'b0;
                rx_cnt    <= 6'd0;
            end else if (!rx_active) begin
                if (!line_in) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= 6'd1;
                    rx_shift  <= '0;
                    rx_crc    <= 7'd0;
                end
            end else begin
                rx_shift <= {rx_shift[44:0], line_in};
                if (rx_cnt < 6'd40) begin
                    rx_crc <= crc7_step(rx_crc, line_in);
                end
                if (rx_cnt == 6'd47) begin
                    rx_active <= 1'b0;
                    rx_cnt    <= 6'd0;
                    if (frame_ok) begin
                        o_cmd_valid <= 1'b1;
                        o_cmd       <= rx_shift[44:39];
                        o_arg       <= rx_shift[38:7];
                    end
                end else begin
                    rx_cnt <= rx_cnt + 6'd1;
                end
            end
        end
    end

    assign data_len  = tx_type ? 8'd128 : 8'd40;
    assign crc_first = tx_type ? 8'd8   : 8'd0;
    assign last_cnt  = tx_type ? 8'd135 : 8'd47;

    // Current response bit: data field, then CRC (or all ones), then the end bit
    always_comb begin
        cur_bit = 1'b1;
        if (tx_cnt < data_len) begin
            cur_bit = tx_shift[127];
        end else if (tx_cnt < last_cnt) begin
            cur_bit = tx_use_crc ? tx_crc[6] : 1'b1;
        end
    end

    assign collide = (tx_state == TX_SEND) && !tx_drive && cur_bit && !line_in;

    // Transmitter state register
    always_ff @(posedge sd_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // Next state and line/status outputs
    always_comb begin
        tx_next   = tx_state;
        o_busy    = 1'b0;
        sd_ds     = 1'b0;
        drive_en  = 1'b0;
        drive_val = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (i_valid) begin
                    tx_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                o_busy  = 1'b1;
                tx_next = TX_SEND;
            end
            TX_SEND: begin
                o_busy = 1'b1;
                sd_ds  = (tx_cnt == last_cnt);
                if (tx_drive) begin
                    drive_en  = 1'b1;
                    drive_val = cur_bit;
                end else begin
                    drive_en  = !cur_bit;
                    drive_val = 1'b0;
                end
                if (collide || (tx_cnt == last_cnt)) begin
                    tx_next = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // Transmitter datapath: latch the request on accept, then shift bits and run the CRC
    always_ff @(posedge sd_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tx_shift    <= '0;
            tx_crc      <= 7'd0;
            tx_cnt      <= 8'd0;
            tx_type     <= 1'b0;
            tx_use_crc  <= 1'b0;
            tx_drive    <= 1'b0;
            o_collision <= 1'b0;
        end else if ((tx_state == TX_IDLE) && i_valid) begin
            tx_type     <= i_type;
            tx_use_crc  <= i_use_crc;
            tx_drive    <= i_drive;
            tx_shift    <= i_type ? {2'b00, 6'h3F, i_arg}
                                  : {2'b00, i_reply, i_arg[31:0], 88'd0};
            tx_crc      <= 7'd0;
            tx_cnt      <= 8'd0;
            o_collision <= 1'b0;
        end else if (tx_state == TX_SEND) begin
            if (collide) begin
                o_collision <= 1'b1;
            end
            if (tx_cnt < data_len) begin
                tx_shift <= {tx_shift[126:0], 1'b0};
                if (tx_cnt >= crc_first) begin
                    tx_crc <= crc7_step(tx_crc, tx_shift[127]);
                end
            end else begin
                tx_crc <= {tx_crc[5:0], 1'b0};
            end
            tx_cnt <= tx_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mdl_sd_cmd.sv
// Testbench for mdl_sd_cmd.
// Host command frames and response requests are driven from tables, and
// expected results are queued. A negedge monitor and the response capture
// pop the queues and compare.
module tb_mdl_sd_cmd;

    typedef struct {
        logic [47:0] frame;
        logic        exp_valid;
        logic [5:0]  exp_cmd;
        logic [31:0] exp_arg;
    } cmd_vec_t;

    typedef struct {
        logic         rtype;
        logic [5:0]   reply;
        logic [119:0] arg;
        logic         use_crc;
        logic         drive;
    } resp_vec_t;

    typedef struct {
        logic [5:0]  cmd;
        logic [31:0] arg;
    } cmd_exp_t;

    typedef struct {
        logic [135:0] frame;
        int           len;
    } resp_exp_t;

    logic         sd_clk;
    logic         i_reset_n;
    wire          sd_line;
    logic         sd_ds;
    logic         o_cmd_valid;
    logic [5:0]   o_cmd;
    logic [31:0]  o_arg;
    logic         i_valid;
    logic         i_type;
    logic [5:0]   i_reply;
    logic [119:0] i_arg;
    logic         i_use_crc;
    logic         o_busy;
    logic         i_drive;
    logic         o_collision;
    logic         host_oe;
    logic         host_val;

    int checks   = 0;
    int failures = 0;

    cmd_exp_t  cmd_q[$];
    resp_exp_t resp_q[$];
    cmd_exp_t  mon_e;
    logic      prev_valid = 1'b0;
    logic [5:0]  last_cmd;
    logic [31:0] last_arg;

    pullup (sd_line);
    assign sd_line = host_oe ? host_val : 1'bz;

    mdl_sd_cmd dut (
        .sd_clk      (sd_clk),
        .i_reset_n   (i_reset_n),
        .sd_cmd      (sd_line),
        .sd_ds       (sd_ds),
        .o_cmd_valid (o_cmd_valid),
        .o_cmd       (o_cmd),
        .o_arg       (o_arg),
        .i_valid     (i_valid),
        .i_type      (i_type),
        .i_reply     (i_reply),
        .i_arg       (i_arg),
        .i_use_crc   (i_use_crc),
        .o_busy      (o_busy),
        .i_drive     (i_drive),
        .o_collision (o_collision)
    );

    initial sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;

    // Reference CRC7 over the low len bits of d, MSB first
    function automatic logic [6:0] model_crc7(input logic [127:0] d, input int len);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = len - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = c << 1;
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [39:0] d);
        return {d, model_crc7({88'd0, d}, 40), 1'b1};
    endfunction

    function automatic resp_exp_t mk_resp(input resp_vec_t r);
        resp_exp_t  e;
        logic [39:0] d40;
        logic [6:0]  c;
        if (!r.rtype) begin
            d40     = {2'b00, r.reply, r.arg[31:0]};
            c       = r.use_crc ? model_crc7({88'd0, d40}, 40) : 7'h7F;
            e.frame = {d40, c, 1'b1, 88'd0};
            e.len   = 48;
        end else begin
            c       = r.use_crc ? model_crc7({8'd0, r.arg}, 120) : 7'h7F;
            e.frame = {2'b00, 6'h3F, r.arg, c, 1'b1};
            e.len   = 136;
        end
        return e;
    endfunction

    task automatic check_output(input string name, input logic [135:0] actual,
                                input logic [135:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Host drives one 48-bit frame; returns just after releasing the line
    task automatic apply_stimulus(input logic [47:0] frame);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            host_oe  = 1'b1;
            host_val = frame[i];
        end
        @(negedge sd_clk);
        host_oe = 1'b0;
    endtask

    // Request a response (called just after a negedge), capture it, and score it
    task automatic run_response(input resp_vec_t r, output logic [135:0] cap);
        resp_exp_t e;
        int        busy_cnt;
        int        ds_err;
        resp_q.push_back(mk_resp(r));
        cap       = '0;
        ds_err    = 0;
        i_valid   = 1'b1;
        i_type    = r.rtype;
        i_reply   = r.reply;
        i_arg     = r.arg;
        i_use_crc = r.use_crc;
        i_drive   = r.drive;
        @(posedge sd_clk);
        #1;
        i_valid = 1'b0;
        i_reply = ~r.reply;
        i_arg   = ~r.arg;
        @(negedge sd_clk);
        check_output("busy after accept", o_busy, 1'b1);
        check_output("collision cleared on accept", o_collision, 1'b0);
        check_output("line idle before start", sd_line, 1'b1);
        busy_cnt = o_busy ? 1 : 0;
        for (int k = 0; k < resp_q[resp_q.size() - 1].len; k++) begin
            @(negedge sd_clk);
            cap[135 - k] = sd_line;
            if (o_busy) busy_cnt++;
            if (sd_ds !== (k == resp_q[resp_q.size() - 1].len - 1)) ds_err++;
        end
        @(negedge sd_clk);
        check_output("busy falls after end bit", {o_busy, sd_ds}, 2'b00);
        e = resp_q.pop_front();
        check_output("busy cycle count", busy_cnt, e.len + 1);
        check_output("sd_ds bad cycles", ds_err, 0);
        check_output($sformatf("response frame len %0d", e.len), cap, e.frame);
    endtask

    // Scoreboard monitor for received commands
    always @(negedge sd_clk) begin
        if (!i_reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if (o_cmd_valid) begin
                if (prev_valid) begin
                    check_output("cmd_valid single cycle", prev_valid, 1'b0);
                end else if (cmd_q.size() == 0) begin
                    check_output("unexpected cmd_valid", o_cmd_valid, 1'b0);
                end else begin
                    mon_e = cmd_q.pop_front();
                    check_output("o_cmd", o_cmd, mon_e.cmd);
                    check_output("o_arg", o_arg, mon_e.arg);
                end
            end
            prev_valid = o_cmd_valid;
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: time limit reached, failures=%0d", failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        cmd_vec_t     cmd_tab[7];
        resp_vec_t    resp_tab[4];
        resp_vec_t    r;
        logic [135:0] cap;
        logic [127:0] rnd;
        logic [31:0]  rarg;
        int           low_cnt;
        int           busy_cnt;

        rarg = $urandom;
        cmd_tab[0] = '{48'h400000000095, 1'b1, 6'd0, 32'd0};
        cmd_tab[1] = '{48'h48000001AA87, 1'b1, 6'd8, 32'h000001AA};
        cmd_tab[2] = '{48'h48000001AA86, 1'b0, 6'd0, 32'd0};
        cmd_tab[3] = '{mk_cmd(40'h08000001AA), 1'b0, 6'd0, 32'd0};
        cmd_tab[4] = '{mk_cmd(40'h5112345678) ^ 48'h1, 1'b0, 6'd0, 32'd0};
        cmd_tab[5] = '{mk_cmd({2'b01, 6'd17, rarg}), 1'b1, 6'd17, rarg};
        cmd_tab[6] = '{mk_cmd({2'b01, 6'd55, 32'hFFFFFFFF}), 1'b1, 6'd55, 32'hFFFFFFFF};

        rnd = {$urandom, $urandom, $urandom, $urandom};
        resp_tab[0] = '{1'b0, 6'd8, 120'h1AA, 1'b1, 1'b1};
        resp_tab[1] = '{1'b0, 6'h3F, 120'h80FF8000, 1'b0, 1'b1};
        resp_tab[2] = '{1'b1, 6'd2, rnd[119:0], 1'b1, 1'b1};
        resp_tab[3] = '{1'b0, 6'h11, {88'd0, $urandom}, 1'b1, 1'b0};

        host_oe   = 1'b0;
        host_val  = 1'b1;
        i_valid   = 1'b0;
        i_type    = 1'b0;
        i_reply   = 6'd0;
        i_arg     = '0;
        i_use_crc = 1'b0;
        i_drive   = 1'b0;
        last_cmd  = 6'd0;
        last_arg  = 32'd0;
        i_reset_n = 1'b0;

        repeat (3) @(negedge sd_clk);
        check_output("reset o_busy", o_busy, 1'b0);
        check_output("reset o_cmd_valid", o_cmd_valid, 1'b0);
        check_output("reset o_cmd", o_cmd, 6'd0);
        check_output("reset o_arg", o_arg, 32'd0);
        check_output("reset o_collision", o_collision, 1'b0);
        check_output("reset sd_ds", sd_ds, 1'b0);
        check_output("reset line released", sd_line, 1'b1);
        i_reset_n = 1'b1;
        repeat (2) @(negedge sd_clk);

        for (int i = 0; i < 7; i++) begin
            if (cmd_tab[i].exp_valid) begin
                cmd_q.push_back('{cmd: cmd_tab[i].exp_cmd, arg: cmd_tab[i].exp_arg});
                last_cmd = cmd_tab[i].exp_cmd;
                last_arg = cmd_tab[i].exp_arg;
            end
            apply_stimulus(cmd_tab[i].frame);
            repeat (3) @(negedge sd_clk);
            check_output($sformatf("cmd hold %0d", i), o_cmd, last_cmd);
            check_output($sformatf("arg hold %0d", i), o_arg, last_arg);
        end

        for (int i = 0; i < 4; i++) begin
            run_response(resp_tab[i], cap);
            check_output($sformatf("no collision resp %0d", i), o_collision, 1'b0);
            if (i == 1) begin
                check_output("no-crc field", cap[95:89], 7'h7F);
                check_output("no-crc end bit", cap[88], 1'b1);
            end
            repeat (2) @(negedge sd_clk);
        end

        // Response accepted in the same cycle a command is reported
        cmd_q.push_back('{cmd: 6'd8, arg: 32'h000001AA});
        last_cmd = 6'd8;
        last_arg = 32'h000001AA;
        apply_stimulus(48'h48000001AA87);
        check_output("cmd_valid at accept", o_cmd_valid, 1'b1);
        r = '{1'b0, 6'd8, 120'h1AA, 1'b1, 1'b1};
        run_response(r, cap);
        repeat (2) @(negedge sd_clk);

        // Open-drain collision on a released one bit
        rnd = {$urandom, $urandom, $urandom, $urandom};
        i_valid   = 1'b1;
        i_type    = 1'b1;
        i_reply   = 6'd5;
        i_arg     = rnd[119:0];
        i_use_crc = 1'b1;
        i_drive   = 1'b0;
        @(posedge sd_clk);
        #1;
        i_valid = 1'b0;
        @(negedge sd_clk);
        @(negedge sd_clk);
        check_output("od start bit low", sd_line, 1'b0);
        @(negedge sd_clk);
        check_output("od direction bit low", sd_line, 1'b0);
        @(negedge sd_clk);
        check_output("collision before pull", o_collision, 1'b0);
        host_oe  = 1'b1;
        host_val = 1'b0;
        @(negedge sd_clk);
        host_oe = 1'b0;
        check_output("collision flag", o_collision, 1'b1);
        check_output("busy after collision", o_busy, 1'b0);
        #1;
        check_output("line released after collision", sd_line, 1'b1);
        check_output("sd_ds after collision", sd_ds, 1'b0);
        repeat (3) @(negedge sd_clk);
        check_output("collision holds", o_collision, 1'b1);
        r = '{1'b0, 6'd2, {88'd0, $urandom}, 1'b1, 1'b1};
        run_response(r, cap);
        repeat (2) @(negedge sd_clk);

        // Reset in the middle of a 136-bit response
        i_valid   = 1'b1;
        i_type    = 1'b1;
        i_reply   = 6'd0;
        i_arg     = '0;
        i_use_crc = 1'b1;
        i_drive   = 1'b1;
        @(posedge sd_clk);
        #1;
        i_valid = 1'b0;
        repeat (60) @(negedge sd_clk);
        check_output("mid-response line low", sd_line, 1'b0);
        i_reset_n = 1'b0;
        #1;
        check_output("reset abort busy", o_busy, 1'b0);
        check_output("reset abort sd_ds", sd_ds, 1'b0);
        check_output("reset abort line", sd_line, 1'b1);
        check_output("reset clears o_cmd", o_cmd, 6'd0);
        check_output("reset clears o_arg", o_arg, 32'd0);
        repeat (2) @(negedge sd_clk);
        i_reset_n = 1'b1;
        low_cnt  = 0;
        busy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge sd_clk);
            if (sd_line === 1'b0) low_cnt++;
            if (o_busy) busy_cnt++;
        end
        check_output("no bits after abort", low_cnt, 0);
        check_output("no busy after abort", busy_cnt, 0);
        cmd_q.push_back('{cmd: 6'd17, arg: rarg});
        last_cmd = 6'd17;
        last_arg = rarg;
        apply_stimulus(mk_cmd({2'b01, 6'd17, rarg}));
        repeat (3) @(negedge sd_clk);
        check_output("post-reset cmd", o_cmd, last_cmd);
        check_output("post-reset arg", o_arg, last_arg);

        check_output("pending command expectations", cmd_q.size(), 0);
        check_output("pending response expectations", resp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdl_sd_cmd.md
MDL_SD_CMD -- requirements
Module: mdl_sd_cmd

Interface
REQ-001 SHALL have port sd_clk, input, 1: sole clock; all sampling and driving on its rising edge.
REQ-002 SHALL have port i_reset_n, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port sd_cmd, inout, 1: SD CMD line; host frames in, card responses out; high-Z when not driving.
REQ-004 SHALL have port sd_ds, output, 1: data strobe, high only during the cycle the response end bit is driven.
REQ-005 SHALL have ports o_cmd_valid (output, 1), o_cmd (output, 6), o_arg (output, 32): received-command pulse, index, argument.
REQ-006 SHALL have ports i_valid (input, 1), i_type (input, 1; 0=48-bit, 1=136-bit), i_reply (input, 6; index field), i_arg (input, 120; payload), i_use_crc (input, 1): response request.
REQ-007 SHALL have port o_busy, output, 1: response accepted and not yet complete.
REQ-008 SHALL have port i_drive, input, 1: 1=push-pull, 0=open-drain response mode.
REQ-009 SHALL have port o_collision, output, 1: open-drain collision flag.
REQ-010 SHALL have no parameters.

Function
REQ-011 Receiver SHALL idle until it samples sd_cmd=0 while not transmitting, then shift 48 bits MSB first: start 0, direction 1, index[5:0], arg[31:0], CRC7, end 1.
REQ-012 CRC7 SHALL use polynomial x^7+x^3+1, init 0, over the first 40 frame bits.
REQ-013 A frame with direction=1, correct CRC and end=1 SHALL pulse o_cmd_valid for exactly one cycle, the cycle after the end bit is sampled, with o_cmd/o_arg held until the next valid frame; any other frame SHALL be silently discarded.
REQ-014 Z or X on sd_cmd SHALL read as 1 (pull-up).
REQ-015 Response SHALL be accepted on a rising edge where i_valid=1 and o_busy=0; i_type, i_reply, i_arg, i_use_crc, i_drive latched then; o_busy high from the next cycle.
REQ-016 i_valid while o_busy=1 SHALL be ignored (requester holds it).
REQ-017 Start bit SHALL appear on the second rising edge after acceptance; sd_cmd stays Z in between.
REQ-018 i_type=0: 48 bits = 0, 0, i_reply[5:0], i_arg[31:0], CRC7 over preceding 40 bits, 1.
REQ-019 i_type=1: 136 bits = 0, 0, 6'b111111, i_arg[119:0], CRC7 over i_arg only, 1 (i_reply ignored).
REQ-020 i_use_crc=0: CRC field SHALL be 7'h7F.
REQ-021 o_busy SHALL fall the cycle after the end bit; sd_cmd returns to Z that cycle.
REQ-022 i_drive=1: drive every bit push-pull.
REQ-023 i_drive=0: drive 0 for zero bits, release (Z) for one bits; any released bit sampled 0 SHALL set o_collision and abort: release line, o_busy low next cycle.
REQ-024 o_collision SHALL clear when a new response is accepted; otherwise holds.
REQ-025 Receiver SHALL ignore sd_cmd while o_busy=1 and resume hunting the cycle after o_busy falls.
REQ-026 Accepted command and response SHALL be independent: a response may be accepted the same cycle o_cmd_valid pulses.

Reset
REQ-027 i_reset_n=0 SHALL immediately: release sd_cmd (Z), clear o_cmd_valid, o_cmd, o_arg, o_busy, o_collision, sd_ds, abort any frame in progress.
REQ-028 After release, receiver SHALL hunt for a start bit; an abort mid-response SHALL emit no further bits.

Verification
REQ-029 Host sends 0x40_00000000_95 -> one o_cmd_valid pulse, o_cmd=0, o_arg=0.
REQ-030 Host sends 0x48_000001AA_87 -> o_cmd=8, o_arg=32'h000001AA; same frame with CRC 0x86 -> no pulse.
REQ-031 i_valid, i_type=0, i_reply=8, i_arg[31:0]=0x1AA, i_use_crc=1, i_drive=1 -> line carries 0x08_000001AA followed by CRC7(0x08000001AA) and end bit 1 on the 2nd edge after accept; o_busy high 49 cycles; sd_ds one cycle at end bit.
REQ-032 i_type=1, i_arg=random CID, i_drive=0, bench pulls line low on a released 1 bit -> o_collision=1, line released, o_busy low next cycle; next accepted response clears o_collision.
REQ-033 i_use_crc=0, i_reply=6'h3F, i_arg[31:0]=0x80FF8000 -> CRC field 7'h7F, end bit 1.
REQ-034 Assert i_reset_n=0 midway through a 136-bit response -> sd_cmd Z, o_busy=0 immediately; next host command decoded normally.
